// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for load responses, aligns/extends load data, registers write-back.
// Optional build macro MEM_MISALIGN_CHECK_EN adds the wb_pipe_exc_load_mis output.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_OP_WIDTH
`define MEM_OP_WIDTH 3
`endif
`ifndef REG_AW
`define REG_AW 5
`endif

module mem_stage #(
  parameter bit LOAD_FWD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_pipe_ready,
  output logic                     mem_pipe_flush,
  input  logic                     mem_pipe_valid,
  input  logic [`XLEN-1:0]         mem_pipe_pc,
  input  logic [`XLEN-1:0]         mem_pipe_instruction,
  input  logic [`MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
  input  logic                     mem_pipe_mem_read,
  input  logic [1:0]               mem_pipe_mem_byte_addr,
  input  logic                     mem_pipe_unsign,
  input  logic                     mem_pipe_rd_write,
  input  logic [`REG_AW-1:0]       mem_pipe_rd_addr,
  input  logic [`XLEN-1:0]         mem_pipe_alu_result,
  input  logic                     dram_rvalid,
  input  logic [`XLEN-1:0]         dram_rdata,
  input  logic                     wb_pipe_ready,
  input  logic                     wb_pipe_flush,
  output logic                     wb_pipe_valid,
  output logic [`XLEN-1:0]         wb_pipe_pc,
  output logic [`XLEN-1:0]         wb_pipe_instruction,
  output logic                     wb_pipe_rd_write,
  output logic [`REG_AW-1:0]       wb_pipe_rd_addr,
  output logic [`XLEN-1:0]         wb_pipe_rd_wdata,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                     wb_pipe_exc_load_mis,
`endif
  output logic                     mem_rd_write,
  output logic [`REG_AW-1:0]       mem_rd_addr,
  output logic [`XLEN-1:0]         mem_rd_wdata,
  output logic                     mem_load_pending
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [`XLEN-1:0] hold_data_reg;
  logic             hold_capture;
  logic             hold_vld;
  logic             mem_valid;
  logic             resp_ok;
  logic             mem_done;
  logic             wb_load;
  logic             misaligned;
  logic             rd_write_eff;
  logic [`XLEN-1:0] load_word;
  logic [`XLEN-1:0] byte_src;
  logic [`XLEN-1:0] half_src;
  logic [`XLEN-1:0] aligned_load;
  logic [`XLEN-1:0] rd_wdata;

  assign hold_vld  = (state_reg == S_HOLD);
  assign mem_valid = mem_pipe_valid & ~wb_pipe_flush;
  // A response seen while draining belongs to a killed load, never to the occupant.
  assign resp_ok   = dram_rvalid & (state_reg != S_DRAIN);
  assign mem_done  = ~mem_pipe_mem_read | resp_ok | hold_vld;
  assign wb_load   = wb_pipe_ready & mem_done;

  assign mem_pipe_ready = (~mem_valid | (mem_done & wb_pipe_ready)) & (state_reg != S_DRAIN);
  assign mem_pipe_flush = wb_pipe_flush;

  // Load alignment and extension (opcode bit 0 = BYTE, 1 = HALF, 2 = WORD)
  assign load_word = hold_vld ? hold_data_reg : dram_rdata;
  assign byte_src  = load_word >> {mem_pipe_mem_byte_addr, 3'b000};
  assign half_src  = load_word >> {mem_pipe_mem_byte_addr[1], 4'b0000};

  always_comb begin
    aligned_load = load_word;
    if (mem_pipe_mem_opcode[0])
      aligned_load = {{24{~mem_pipe_unsign & byte_src[7]}}, byte_src[7:0]};
    else if (mem_pipe_mem_opcode[1])
      aligned_load = {{16{~mem_pipe_unsign & half_src[15]}}, half_src[15:0]};
  end

  assign rd_wdata = mem_pipe_mem_read ? aligned_load : mem_pipe_alu_result;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = mem_pipe_mem_read &
                      ((mem_pipe_mem_opcode[1] & mem_pipe_mem_byte_addr[0]) |
                       (mem_pipe_mem_opcode[2] & (mem_pipe_mem_byte_addr != 2'd0)));
`else
  assign misaligned = 1'b0;
`endif

  assign rd_write_eff = mem_pipe_rd_write & ~misaligned;

  // Forward to decode
  assign mem_rd_addr  = mem_pipe_rd_addr;
  assign mem_rd_wdata = rd_wdata;
  assign mem_rd_write = rd_write_eff & mem_valid & (LOAD_FWD | ~mem_pipe_mem_read);
  assign mem_load_pending = mem_valid & mem_pipe_mem_read & ~(LOAD_FWD & (resp_ok | hold_vld));

  always_comb begin
    state_next   = state_reg;
    hold_capture = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (mem_pipe_valid & mem_pipe_mem_read & ~dram_rvalid)
          // A load killed before its response arrives still has a request outstanding.
          state_next = wb_pipe_flush ? S_DRAIN : S_WAIT;
        else if (mem_valid & mem_pipe_mem_read & dram_rvalid & ~wb_pipe_ready) begin
          state_next   = S_HOLD;
          hold_capture = 1'b1;
        end
      end
      S_WAIT: begin
        if (wb_pipe_flush)
          state_next = dram_rvalid ? S_IDLE : S_DRAIN;
        else if (dram_rvalid) begin
          if (wb_pipe_ready)
            state_next = S_IDLE;
          else begin
            state_next   = S_HOLD;
            hold_capture = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (wb_pipe_flush | wb_pipe_ready)
          state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (dram_rvalid)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      wb_pipe_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (wb_pipe_ready)
        wb_pipe_valid <= mem_valid & mem_done;
    end
  end

  always_ff @(posedge clk) begin
    if (hold_capture)
      hold_data_reg <= dram_rdata;
    if (wb_load) begin
      wb_pipe_pc          <= mem_pipe_pc;
      wb_pipe_instruction <= mem_pipe_instruction;
      wb_pipe_rd_write    <= rd_write_eff;
      wb_pipe_rd_addr     <= mem_pipe_rd_addr;
      wb_pipe_rd_wdata    <= rd_wdata;
`ifdef MEM_MISALIGN_CHECK_EN
      wb_pipe_exc_load_mis <= misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads with/without wait, extension, HOLD, DRAIN and ALU pass-through.
`timescale 1ns/1ps
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
  logic [31:0] mem_pipe_pc, mem_pipe_instruction;
  logic [2:0]  mem_pipe_mem_opcode;
  logic        mem_pipe_mem_read;
  logic [1:0]  mem_pipe_mem_byte_addr;
  logic        mem_pipe_unsign, mem_pipe_rd_write;
  logic [4:0]  mem_pipe_rd_addr;
  logic [31:0] mem_pipe_alu_result;
  logic        dram_rvalid;
  logic [31:0] dram_rdata;
  logic        wb_pipe_ready, wb_pipe_flush, wb_pipe_valid;
  logic [31:0] wb_pipe_pc, wb_pipe_instruction;
  logic        wb_pipe_rd_write;
  logic [4:0]  wb_pipe_rd_addr;
  logic [31:0] wb_pipe_rd_wdata;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        wb_pipe_exc_load_mis;
`endif
  logic        mem_rd_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_rd_wdata;
  logic        mem_load_pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_pipe_ready(mem_pipe_ready), .mem_pipe_flush(mem_pipe_flush),
    .mem_pipe_valid(mem_pipe_valid), .mem_pipe_pc(mem_pipe_pc),
    .mem_pipe_instruction(mem_pipe_instruction), .mem_pipe_mem_opcode(mem_pipe_mem_opcode),
    .mem_pipe_mem_read(mem_pipe_mem_read), .mem_pipe_mem_byte_addr(mem_pipe_mem_byte_addr),
    .mem_pipe_unsign(mem_pipe_unsign), .mem_pipe_rd_write(mem_pipe_rd_write),
    .mem_pipe_rd_addr(mem_pipe_rd_addr), .mem_pipe_alu_result(mem_pipe_alu_result),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .wb_pipe_ready(wb_pipe_ready), .wb_pipe_flush(wb_pipe_flush),
    .wb_pipe_valid(wb_pipe_valid), .wb_pipe_pc(wb_pipe_pc),
    .wb_pipe_instruction(wb_pipe_instruction), .wb_pipe_rd_write(wb_pipe_rd_write),
    .wb_pipe_rd_addr(wb_pipe_rd_addr), .wb_pipe_rd_wdata(wb_pipe_rd_wdata),
`ifdef MEM_MISALIGN_CHECK_EN
    .wb_pipe_exc_load_mis(wb_pipe_exc_load_mis),
`endif
    .mem_rd_write(mem_rd_write), .mem_rd_addr(mem_rd_addr),
    .mem_rd_wdata(mem_rd_wdata), .mem_load_pending(mem_load_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic vld, input logic rd, input logic [2:0] op, input logic [1:0] ba,
                       input logic uns, input logic [4:0] rda, input logic [31:0] alu);
    mem_pipe_valid         = vld;
    mem_pipe_mem_read      = rd;
    mem_pipe_mem_opcode    = op;
    mem_pipe_mem_byte_addr = ba;
    mem_pipe_unsign        = uns;
    mem_pipe_rd_write      = 1'b1;
    mem_pipe_rd_addr       = rda;
    mem_pipe_alu_result    = alu;
    mem_pipe_pc            = {20'h0, 7'h0, rda, 0 ? 0 : 0} | 32'h100;
    mem_pipe_instruction   = 32'h0000_0013;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 3'b100, 2'd0, 1'b0, 5'd0, 32'h0);
    dram_rvalid   = 1'b0;
    dram_rdata    = 32'h0;
    wb_pipe_ready = 1'b1;
    wb_pipe_flush = 1'b0;
  endtask

  // Single load that sees its response in the first MEM cycle.
  task automatic quick_load(input string tag, input logic [2:0] op, input logic [1:0] ba,
                            input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
    drive(1'b1, 1'b1, op, ba, uns, 5'd7, 32'h0);
    dram_rvalid = 1'b1;
    dram_rdata  = rdata;
    settle();
    check({tag, "_fwd"}, mem_rd_wdata, exp);
    tick();
    idle_in();
    settle();
    check({tag, "_wb"}, wb_pipe_rd_wdata, exp);
    $display("[TB] %s rdata=%h -> %h", tag, rdata, wb_pipe_rd_wdata);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_wb_valid", {31'b0, wb_pipe_valid}, 32'd0);
    check("rst_ready", {31'b0, mem_pipe_ready}, 32'd1);
    check("rst_pending", {31'b0, mem_load_pending}, 32'd0);

    // LW with one WAIT cycle
    tick();
    drive(1'b1, 1'b1, 3'b100, 2'd0, 1'b0, 5'd5, 32'h0);
    settle();
    check("lw_wait_ready", {31'b0, mem_pipe_ready}, 32'd0);
    check("lw_wait_pending", {31'b0, mem_load_pending}, 32'd1);
    tick();
    dram_rvalid = 1'b1;
    dram_rdata  = 32'hDEADBEEF;
    settle();
    check("lw_resp_ready", {31'b0, mem_pipe_ready}, 32'd1);
    check("lw_resp_pending", {31'b0, mem_load_pending}, 32'd0);
    check("lw_resp_fwd", mem_rd_wdata, 32'hDEADBEEF);
    tick();
    idle_in();
    settle();
    check("lw_wb_valid", {31'b0, wb_pipe_valid}, 32'd1);
    check("lw_wb_data", wb_pipe_rd_wdata, 32'hDEADBEEF);
    check("lw_wb_addr", {27'b0, wb_pipe_rd_addr}, 32'd5);
    check("lw_wb_write", {31'b0, wb_pipe_rd_write}, 32'd1);
    $display("[TB] LW -> %h", wb_pipe_rd_wdata);

    // Byte / half alignment and extension
    quick_load("lb3",  3'b001, 2'd3, 1'b0, 32'h80123456, 32'hFFFFFF80);
    quick_load("lbu3", 3'b001, 2'd3, 1'b1, 32'h80123456, 32'h00000080);
    quick_load("lh2",  3'b010, 2'd2, 1'b0, 32'h80011234, 32'hFFFF8001);
    quick_load("lb1",  3'b001, 2'd1, 1'b0, 32'h00007F00, 32'h0000007F);
    quick_load("lhu0", 3'b010, 2'd0, 1'b1, 32'h0000ABCD, 32'h0000ABCD);

    // HOLD: response arrives while WB stalls for 3 cycles
    tick();
    drive(1'b1, 1'b1, 3'b100, 2'd0, 1'b0, 5'd9, 32'h0);
    dram_rvalid   = 1'b1;
    dram_rdata    = 32'h12345678;
    wb_pipe_ready = 1'b0;
    settle();
    check("hold_ready0", {31'b0, mem_pipe_ready}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      tick();
      dram_rvalid = 1'b0;
      dram_rdata  = 32'h5555AAAA;
      settle();
      check("hold_ready", {31'b0, mem_pipe_ready}, 32'd0);
      check("hold_fwd", mem_rd_wdata, 32'h12345678);
    end
    tick();
    wb_pipe_ready = 1'b1;
    settle();
    check("hold_release_ready", {31'b0, mem_pipe_ready}, 32'd1);
    tick();
    idle_in();
    settle();
    check("hold_wb_valid", {31'b0, wb_pipe_valid}, 32'd1);
    check("hold_wb_data", wb_pipe_rd_wdata, 32'h12345678);
    $display("[TB] HOLD load -> %h", wb_pipe_rd_wdata);

    // DRAIN: flush while waiting, response two cycles later
    tick();
    drive(1'b1, 1'b1, 3'b100, 2'd0, 1'b0, 5'd4, 32'h0);
    tick();
    wb_pipe_flush = 1'b1;
    settle();
    check("flush_pass", {31'b0, mem_pipe_flush}, 32'd1);
    tick();
    idle_in();
    settle();
    check("drain_wb_valid", {31'b0, wb_pipe_valid}, 32'd0);
    check("drain_ready", {31'b0, mem_pipe_ready}, 32'd0);
    tick();
    dram_rvalid = 1'b1;
    dram_rdata  = 32'hBAD0BAD0;
    settle();
    check("drain_resp_ready", {31'b0, mem_pipe_ready}, 32'd0);
    tick();
    dram_rvalid = 1'b0;
    settle();
    check("drain_exit_ready", {31'b0, mem_pipe_ready}, 32'd1);
    check("drain_exit_wb_valid", {31'b0, wb_pipe_valid}, 32'd0);
    $display("[TB] DRAIN sequence done");

    // Back-to-back ALU results
    tick();
    drive(1'b1, 1'b0, 3'b100, 2'd0, 1'b0, 5'd3, 32'd11);
    settle();
    check("add1_fwd_we", {31'b0, mem_rd_write}, 32'd1);
    check("add1_fwd_data", mem_rd_wdata, 32'd11);
    check("add1_ready", {31'b0, mem_pipe_ready}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 3'b100, 2'd0, 1'b0, 5'd6, 32'd22);
    settle();
    check("add1_wb", wb_pipe_rd_wdata, 32'd11);
    check("add2_fwd_data", mem_rd_wdata, 32'd22);
    tick();
    idle_in();
    settle();
    check("add2_wb", wb_pipe_rd_wdata, 32'd22);
    check("add2_wb_addr", {27'b0, wb_pipe_rd_addr}, 32'd6);
    check("add2_wb_valid", {31'b0, wb_pipe_valid}, 32'd1);
    $display("[TB] ADD pair -> %0d", wb_pipe_rd_wdata);
    tick();
    settle();
    check("idle_wb_valid", {31'b0, wb_pipe_valid}, 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    tick();
    drive(1'b1, 1'b1, 3'b100, 2'd2, 1'b0, 5'd8, 32'h0);
    dram_rvalid = 1'b1;
    dram_rdata  = 32'hCAFEF00D;
    tick();
    idle_in();
    settle();
    check("mis_exc", {31'b0, wb_pipe_exc_load_mis}, 32'd1);
    check("mis_rd_write", {31'b0, wb_pipe_rd_write}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
